// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: receiver state encoding and slot-counter sizing.
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Slot index needs at least one bit even for degenerate sizes.
  function automatic int unsigned slot_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Frame slot counter: clear, load to slot 1, or advance with explicit wrap at N_CH-1.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned SW = slot_width(N_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          load1,
  output logic [SW-1:0] slot,
  output logic          at_last
);

  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (inc) begin
      slot <= (slot == LAST) ? '0 : slot + 1'b1;
    end
  end

  assign at_last = (slot == LAST);

endmodule

// File: rtl/tdm_demux.sv
// TDM link receiver: locks to fsync-marked frames and steers each beat to its channel register.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              fsync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int unsigned SW = slot_width(N_CH);

  state_e                   state;
  logic [SW-1:0]            slot;
  logic                     at_last;
  logic [N_CH-1:0][W-1:0]   bank;
  logic                     cnt_clr;
  logic                     cnt_inc;
  logic                     cnt_load1;

  // Any fsync beat is taken as slot 0, so the counter always restarts at 1 on it.
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    if (din_valid) begin
      if (fsync) begin
        cnt_load1 = 1'b1;
      end else if (state == ST_LOCKED) begin
        if (slot == '0) cnt_clr = 1'b1;
        else            cnt_inc = 1'b1;
      end
    end
  end

  tdm_slot_counter #(.N_CH(N_CH)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .load1   (cnt_load1),
    .slot    (slot),
    .at_last (at_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      bank       <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        if (fsync) begin
          bank[0]  <= din;
          ch_valid <= N_CH'(1);
          state    <= ST_LOCKED;
          locked   <= 1'b1;
          if (state == ST_LOCKED && slot != '0) sync_err <= 1'b1;
        end else if (state == ST_LOCKED) begin
          if (slot == '0) begin
            sync_err <= 1'b1;
            state    <= ST_HUNT;
            locked   <= 1'b0;
          end else begin
            bank[slot]  <= din;
            ch_valid    <= N_CH'(1) << slot;
            frame_done  <= at_last;
          end
        end
      end
    end
  end

  assign ch_data = bank;

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized scoreboard bench for tdm_demux against a frame-level reference model.
module tb_tdm_demux;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 8;

  logic              clk;
  logic              rst_n;
  logic [W-1:0]      din;
  logic              din_valid;
  logic              fsync;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0]   v;
    logic              fd;
    logic              se;
    logic              lk;
    logic [N_CH*W-1:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: link lock flag, index of the next expected slot, channel contents.
  bit         m_locked = 0;
  int         m_slot   = 0;
  logic [W-1:0] m_ch [N_CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit fs, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    rst_n     = !rst;
    din_valid = v;
    fsync     = fs;
    din       = d;
    e.v  = '0;
    e.fd = 1'b0;
    e.se = 1'b0;
    if (rst) begin
      m_locked = 0;
      m_slot   = 0;
      for (int i = 0; i < N_CH; i++) m_ch[i] = '0;
    end else if (v) begin
      if (fs) begin
        if (m_locked && m_slot != 0) e.se = 1'b1;
        m_ch[0]  = d;
        e.v[0]   = 1'b1;
        m_slot   = 1;
        m_locked = 1;
      end else if (m_locked) begin
        if (m_slot == 0) begin
          e.se     = 1'b1;
          m_locked = 0;
        end else begin
          m_ch[m_slot]  = d;
          e.v[m_slot]   = 1'b1;
          e.fd          = (m_slot == N_CH - 1);
          m_slot        = (m_slot + 1) % N_CH;
        end
      end
    end
    e.lk = m_locked;
    for (int i = 0; i < N_CH; i++) e.d[i*W +: W] = m_ch[i];
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0);
  endtask

  // Monitor: every clock edge that followed a driven cycle has one expected record.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ch_valid",   64'(ch_valid),   64'(e.v));
        chk("frame_done", 64'(frame_done), 64'(e.fd));
        chk("sync_err",   64'(sync_err),   64'(e.se));
        chk("locked",     64'(locked),     64'(e.lk));
        chk("ch_data",    64'(ch_data),    64'(e.d));
        checks++;
        if (!$onehot0(ch_valid)) begin
          errors++;
          $display("FAIL ch_valid_onehot: got %b expected at most one bit at %0t", ch_valid, $time);
        end
      end
    end
  end

  initial begin
    bit v, fs, r;
    rst_n = 1'b0; din_valid = 1'b0; fsync = 1'b0; din = '0;
    for (int i = 0; i < N_CH; i++) m_ch[i] = '0;

    drive(1, 0, 0, '0);
    drive(1, 0, 0, '0);

    // Hunt discard, then lock on a back-to-back frame
    drive(0, 1, 0, 8'h11);
    drive(0, 1, 0, 8'h22);
    drive(0, 1, 1, 8'hA0);
    drive(0, 1, 0, 8'hB1);
    drive(0, 1, 0, 8'hC2);
    drive(0, 1, 0, 8'hD3);
    idle(1);
    chk("frame1_data", 64'(ch_data), 64'h0000_0000_D3C2_B1A0);
    chk("frame1_locked", 64'(locked), 64'd1);

    // Gapped frame
    drive(0, 1, 1, 8'h10); idle(3);
    drive(0, 1, 0, 8'h20); idle(3);
    drive(0, 1, 0, 8'h30); idle(3);
    drive(0, 1, 0, 8'h40); idle(1);
    chk("gap_data", 64'(ch_data), 64'h0000_0000_4030_2010);

    // Early sync
    drive(0, 1, 1, 8'h10);
    drive(0, 1, 0, 8'h20);
    drive(0, 1, 1, 8'h99);
    drive(0, 1, 0, 8'h77);
    idle(1);
    chk("early_sync_data", 64'(ch_data), 64'h0000_0000_4030_7799);
    drive(0, 1, 0, 8'h88);
    drive(0, 1, 0, 8'h89);

    // Missing sync after a complete frame, then re-lock
    drive(0, 1, 1, 8'h01);
    drive(0, 1, 0, 8'h02);
    drive(0, 1, 0, 8'h03);
    drive(0, 1, 0, 8'h04);
    drive(0, 1, 0, 8'h55);
    idle(1);
    chk("missing_sync_unlocked", 64'(locked), 64'd0);
    drive(0, 1, 0, 8'h56);
    drive(0, 1, 1, 8'h66);
    drive(0, 1, 0, 8'h67);

    // Reset mid-frame
    drive(0, 1, 1, 8'h01);
    drive(0, 1, 0, 8'h02);
    drive(0, 1, 0, 8'h03);
    drive(1, 1, 0, 8'hEE);
    idle(1);
    chk("reset_clears_data", 64'(ch_data), 64'd0);
    drive(0, 1, 0, 8'h45);
    drive(0, 1, 1, 8'h44);
    drive(0, 1, 0, 8'h45);

    // Random traffic, mostly well-formed framing with occasional violations and resets
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom % 10) < 7;
      r  = ($urandom % 60) == 0;
      if (m_slot == 0) fs = ($urandom % 8) != 0;
      else             fs = ($urandom % 12) == 0;
      drive(r, v, fs, W'($urandom));
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
